// File: rtl/uart_rx_framer.sv
// uart_rx_framer: groups an AXI-stream byte stream into tlast-delimited frames through a FIFO
// Frames close on DELIM, after MAX_LEN bytes, or after TIMEOUT idle cycles.
// Ports: clk, rst_n (async active-low); s_axis_* byte input with tready backpressure;
//        m_axis_* framed byte output with tlast; fifo_level = occupied FIFO entries.
module uart_rx_framer #(
  parameter int DEPTH = 16,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 1000,
  parameter logic [7:0] DELIM = 8'h0A
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);
  logic          h_valid, h_last, tmo_pend;
  logic [7:0]    h_data;
  logic [LW-1:0] len, byte_idx;
  logic [TW-1:0] timer;
  logic [PW-1:0] wp, rp;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    head;
  logic          full, empty, accept, push, pop, new_last, cnt_en;
  assign full          = wp[AW-1:0] == rp[AW-1:0] && wp[AW] != rp[AW];
  assign empty         = wp == rp;
  assign s_axis_tready = !h_valid || !full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign push          = h_valid && !full && (h_last || accept || tmo_pend);
  assign pop           = !empty && m_axis_tready;
  // a timeout push closes the open frame, so a byte accepted alongside it starts a new one
  assign byte_idx      = tmo_pend ? '0 : len;
  assign new_last      = s_axis_tdata == DELIM || byte_idx == LW'(MAX_LEN - 1);
  assign cnt_en        = h_valid && !h_last && !tmo_pend && !accept;
  assign head          = mem[rp[AW-1:0]];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? 8'h00 : head[7:0];
  assign m_axis_tlast  = !empty && head[8];
  assign fifo_level    = wp - rp;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {h_last || tmo_pend, h_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_valid  <= 1'b0;
      h_last   <= 1'b0;
      h_data   <= '0;
      len      <= '0;
      timer    <= '0;
      tmo_pend <= 1'b0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      if (accept) begin
        h_valid <= 1'b1;
        h_data  <= s_axis_tdata;
        h_last  <= new_last;
      end else if (push) h_valid <= 1'b0;
      if (accept) len <= new_last ? '0 : byte_idx + LW'(1);
      else if (push && tmo_pend) len <= '0;
      timer    <= (accept || push) ? '0 : timer + TW'(cnt_en);
      tmo_pend <= push ? 1'b0 : tmo_pend || (cnt_en && timer == TW'(TIMEOUT - 2));
      wp       <= wp + PW'(push);
      rp       <= rp + PW'(pop);
    end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed self-checking bench for uart_rx_framer
module tb_uart_rx_framer;
  localparam int T = 20;
  logic       clk = 1'b0, rst_n;
  logic [7:0] s_tdata, m_tdata;
  logic       s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [4:0] level;
  int         n_chk = 0, n_pass = 0, cyc = 0, k;
  logic [8:0] beats[$];
  int         bcyc[$], acyc[$];
  string      bp = "0123456789:;<=>?@ABC";
  uart_rx_framer #(.DEPTH(16), .MAX_LEN(4), .TIMEOUT(T), .DELIM(8'h0A)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .fifo_level(level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        beats.push_back({m_tlast, m_tdata});
        bcyc.push_back(cyc);
      end
      if (s_tvalid && s_tready) acyc.push_back(cyc);
    end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic clear();
    beats.delete();
    bcyc.delete();
    acyc.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    logic ok = 1'b0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send ready", int'(ok), 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic step();
    @(negedge clk);
    if (s_tvalid && s_tready) k++;
    @(posedge clk);
    #1;
    s_tdata  = k < 20 ? bp[k] : 8'h00;
    s_tvalid = k < 20;
  endtask
  task automatic expect_beats(input string tag, input string s, input logic [31:0] mask);
    check({tag, " count"}, beats.size(), s.len());
    for (int i = 0; i < s.len() && i < beats.size(); i++)
      check($sformatf("%s beat %0d", tag, i), int'(beats[i]), int'({mask[i], s[i]}));
  endtask
  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    #1;
    check("rst s_tready", int'(s_tready), 1);
    check("rst m_tvalid", int'(m_tvalid), 0);
    check("rst m_tdata", int'(m_tdata), 0);
    check("rst m_tlast", int'(m_tlast), 0);
    check("rst level", int'(level), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear();
    send_str("hi\n");
    idle(10);
    expect_beats("delim", "hi\n", 32'h4);
    check("delim latency", (bcyc.size() > 0 && acyc.size() > 0) ? bcyc[0] - acyc[0] : -1, 2);
    clear();
    send_str("abcdefghij");
    idle(2 * T);
    expect_beats("lensplit", "abcdefghij", 32'h288);
    check("tmo push edge", (bcyc.size() > 9 && acyc.size() > 9) ? bcyc[9] - acyc[9] - 1 : -1, T);
    clear();
    send("a");
    repeat (T - 2) @(posedge clk);
    #1;
    send("b");
    check("race gap", acyc.size() > 1 ? acyc[1] - acyc[0] : -1, T - 1);
    idle(2 * T);
    expect_beats("race", "ab", 32'h2);
    clear();
    m_tready = 1'b0;
    k        = 0;
    s_tdata  = bp[0];
    s_tvalid = 1'b1;
    repeat (60) step();
    check("bp accepted", k, 17);
    check("bp level full", int'(level), 16);
    check("bp s_tready low", int'(s_tready), 0);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("bp level after pop", int'(level), 15);
    step();
    check("tmo push after pop", int'(level), 16);
    check("bp s_tready refull", int'(s_tready), 0);
    m_tready = 1'b1;
    repeat (60) step();
    s_tvalid = 1'b0;
    check("bp all accepted", k, 20);
    expect_beats("bp", bp, 32'h98888);
    clear();
    m_tready = 1'b0;
    send_str("abc");
    check("pre-rst level", int'(level), 2);
    rst_n = 1'b0;
    #1;
    check("midrst s_tready", int'(s_tready), 1);
    check("midrst m_tvalid", int'(m_tvalid), 0);
    check("midrst m_tdata", int'(m_tdata), 0);
    check("midrst m_tlast", int'(m_tlast), 0);
    check("midrst level", int'(level), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear();
    m_tready = 1'b1;
    send_str("z\n");
    idle(2 * T);
    expect_beats("post rst", "z\n", 32'h2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
